// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : rf_write_arbiter_if
// Description: Writeback request bundle and register-file write port bundle.
// Revision   : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int N_REQ      = 3
) ();
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*ADDR_WIDTH-1:0] req_reg;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        rf_write_en;
    logic [ADDR_WIDTH-1:0]       rf_write_reg;
    logic [DATA_WIDTH-1:0]       rf_write_data;
    logic [15:0]                 drop_count;

    // Requesters and register file sit on the master side.
    modport master (
        output req_valid, req_reg, req_data,
        input  req_ready, rf_write_en, rf_write_reg, rf_write_data, drop_count
    );

    modport slave (
        input  req_valid, req_reg, req_data,
        output req_ready, rf_write_en, rf_write_reg, rf_write_data, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : rf_write_arbiter
// Description: Round-robin arbiter for N writeback requesters onto a single
//              register-file write port; writes to R0 are consumed and counted.
// Revision   : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int N_REQ      = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rf_write_arbiter_if.slave  bus
);
    localparam int c_PTR_W = $clog2(N_REQ);

    logic [c_PTR_W-1:0]    r_ptr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_reg;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [15:0]           r_drop_count;

    logic [c_PTR_W:0]      w_scan;
    logic [c_PTR_W-1:0]    w_gnt_idx;
    logic [c_PTR_W-1:0]    w_ptr_next;
    logic                  w_gnt_any;
    logic                  w_accept;
    logic [N_REQ-1:0]      w_ready;
    logic [ADDR_WIDTH-1:0] w_sel_reg;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Scan starting at the pointer, wrapping modulo N_REQ; first valid wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_ptr} + (c_PTR_W+1)'(k);
            if (w_scan >= (c_PTR_W+1)'(N_REQ)) begin
                w_scan = w_scan - (c_PTR_W+1)'(N_REQ);
            end
            if (!w_gnt_any && bus.req_valid[w_scan[c_PTR_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan[c_PTR_W-1:0];
            end
        end
    end

    // No transfer is ever accepted while reset is asserted.
    assign w_accept = w_gnt_any && !reset;

    always_comb begin
        w_ready    = '0;
        w_sel_reg  = '0;
        w_sel_data = '0;
        if (w_accept) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == c_PTR_W'(i)) begin
                w_sel_reg  = bus.req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == c_PTR_W'(N_REQ-1)) ? '0
                                                         : w_gnt_idx + c_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_reg     <= '0;
            r_wr_data    <= '0;
            r_drop_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept) begin
                r_ptr <= w_ptr_next;
                // R0 is hardwired zero: consume the write, keep the port quiet.
                if (w_sel_reg == '0) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end else begin
                    r_wr_en   <= 1'b1;
                    r_wr_reg  <= w_sel_reg;
                    r_wr_data <= w_sel_data;
                end
            end
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.rf_write_en   = r_wr_en;
    assign bus.rf_write_reg  = r_wr_reg;
    assign bus.rf_write_data = r_wr_data;
    assign bus.drop_count    = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_rf_write_arbiter
// Description: Self-checking bench; directed scenarios plus randomized traffic
//              compared every cycle against a behavioural round-robin model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N)) bus ();

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester-side stimulus state
    logic [N-1:0]  s_valid;
    logic [AW-1:0] s_reg  [N];
    logic [DW-1:0] s_data [N];

    always_comb begin
        bus.req_valid = s_valid;
        bus.req_reg   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_reg[i*AW +: AW]  = s_reg[i];
            bus.req_data[i*DW +: DW] = s_data[i];
        end
    end

    // Behavioural model state
    int            m_ptr;
    int            m_last_gnt;
    logic          m_en;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    int            m_drop;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        logic [N-1:0] v;
        if (reset) return -1;
        for (int k = 0; k < N; k++) begin
            v = s_valid >> ((m_ptr + k) % N);
            if (v[0]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        g = exp_grant();
        m_last_gnt = g;
        if (reset) begin
            m_ptr = 0; m_en = 1'b0; m_reg = '0; m_data = '0; m_drop = 0;
        end else begin
            m_en = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (s_reg[g] == '0) begin
                    m_drop = (m_drop + 1) % 65536;
                end else begin
                    m_en = 1'b1; m_reg = s_reg[g]; m_data = s_data[g];
                end
            end
        end
    endtask

    task automatic compare_all();
        int g;
        logic [N-1:0] exp_ready;
        g = exp_grant();
        exp_ready = (g < 0) ? '0 : N'(1 << g);
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("rf_write_en", 64'(bus.rf_write_en), 64'(m_en));
        check("rf_write_reg", 64'(bus.rf_write_reg), 64'(m_reg));
        check("rf_write_data", 64'(bus.rf_write_data), 64'(m_data));
        check("drop_count", 64'(bus.drop_count), 64'(m_drop));
    endtask

    // Compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        s_valid[i] = v;
        s_reg[i]   = r;
        s_data[i]  = d;
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = '0;
        for (int i = 0; i < N; i++) begin
            s_reg[i] = '0; s_data[i] = '0;
        end
        @(posedge clk);
        model_step();
        #1;
        tick();
        tick();
        check("rst_en", 64'(bus.rf_write_en), 64'd0);
        check("rst_reg", 64'(bus.rf_write_reg), 64'd0);
        check("rst_drop", 64'(bus.drop_count), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);

        // Three persistent requesters rotate 0,1,2,0,1,2
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'hA0 + i));
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_ready", 64'(bus.req_ready), 64'(1 << (c % 3)));
            tick();
            check("rr_en", 64'(bus.rf_write_en), 64'd1);
            check("rr_reg", 64'(bus.rf_write_reg), 64'((c % 3) + 1));
        end
        s_valid = '0;

        // Lone requester 2
        set_req(2, 1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        check("single_ready", 64'(bus.req_ready), 64'b100);
        tick();
        check("single_en", 64'(bus.rf_write_en), 64'd1);
        check("single_reg", 64'(bus.rf_write_reg), 64'd7);
        check("single_data", 64'(bus.rf_write_data), 64'hDEADBEEF);
        s_valid = '0;
        tick();
        check("idle_en", 64'(bus.rf_write_en), 64'd0);
        check("idle_data_hold", 64'(bus.rf_write_data), 64'hDEADBEEF);

        // R0 write from requester 1 is consumed and counted
        set_req(1, 1'b1, 5'd0, 32'h1234);
        #1;
        check("r0_ready", 64'(bus.req_ready), 64'b010);
        tick();
        check("r0_en", 64'(bus.rf_write_en), 64'd0);
        check("r0_drop", 64'(bus.drop_count), 64'd1);
        s_valid = '0;

        // Pointer now at 2: requesters 0 and 1 pending -> 0 then 1
        set_req(0, 1'b1, 5'd4, 32'h44);
        set_req(1, 1'b1, 5'd6, 32'h66);
        #1;
        check("wrap_ready0", 64'(bus.req_ready), 64'b001);
        tick();
        check("wrap_reg0", 64'(bus.rf_write_reg), 64'd4);
        s_valid[0] = 1'b0;
        #1;
        check("wrap_ready1", 64'(bus.req_ready), 64'b010);
        tick();
        check("wrap_reg1", 64'(bus.rf_write_reg), 64'd6);
        s_valid = '0;

        // Reset the cycle after a grant of reg 5
        set_req(0, 1'b1, 5'd5, 32'h55);
        tick();
        reset = 1'b1;
        set_req(0, 1'b1, 5'd9, 32'h99);
        set_req(1, 1'b1, 5'd10, 32'hAA);
        #1;
        check("rstmid_ready", 64'(bus.req_ready), 64'd0);
        check("rstmid_inflight_reg", 64'(bus.rf_write_reg), 64'd5);
        tick();
        check("rstmid_en", 64'(bus.rf_write_en), 64'd0);
        check("rstmid_drop", 64'(bus.drop_count), 64'd0);
        reset = 1'b0;
        #1;
        check("rstrel_ready", 64'(bus.req_ready), 64'b001);
        tick();
        check("rstrel_reg", 64'(bus.rf_write_reg), 64'd9);
        s_valid = '0;

        // Drop counter wrap: 65535 R0 writes then one more
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'd0, DW'(i));
        for (int c = 0; c < 65535; c++) tick();
        check("wrap_drop_ffff", 64'(bus.drop_count), 64'hFFFF);
        tick();
        check("wrap_drop_zero", 64'(bus.drop_count), 64'd0);
        check("wrap_drop_en", 64'(bus.rf_write_en), 64'd0);
        s_valid = '0;
        tick();

        // Randomized traffic: requesters hold until the model says accepted
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (s_valid[i] && m_last_gnt == i) s_valid[i] = 1'b0;
                if (!s_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 1'b1,
                            ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31)),
                            DW'($urandom));
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        s_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
